// File: rtl/ws2812_pkg.sv
// Shared timing constants, pixel layout and FSM encoding for the WS2812B pixel serializer.
// Build option WS2812_BRIGHTNESS_EN adds the channel scaling helper.
package ws2812_pkg;

    localparam int CYCLES_PER_BIT = 15;
    localparam int T0H_CYCLES     = 5;
    localparam int T1H_CYCLES     = 10;
    localparam int BITS_PER_PIXEL = 24;
    localparam int CNT_W          = 4;
    localparam int BIT_CNT_W      = 5;

    // Field order is the wire order: green goes out first, MSB first.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } ser_state_t;

`ifdef WS2812_BRIGHTNESS_EN
    // (ch * (level + 1)) >> 8: level 255 passes ch through, level 0 forces 0.
    function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] level);
        logic [15:0] product;
        product = 16'(ch) * (16'(level) + 16'd1);
        return 8'(product >> 8);
    endfunction
`endif

endpackage

// File: rtl/ws2812_pixel_serializer_if.sv
// Controller <-> serializer signal bundle. Build option WS2812_BRIGHTNESS_EN adds the
// brightness input.
interface ws2812_pixel_serializer_if;

    logic       load_sreg;
    logic       transmit_pixel;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] brightness;
`endif
    logic       data;
    logic       busy;
    logic       pixel_done;

    modport master (
        output load_sreg, transmit_pixel, red, green, blue,
`ifdef WS2812_BRIGHTNESS_EN
        output brightness,
`endif
        input  data, busy, pixel_done
    );

    modport slave (
        input  load_sreg, transmit_pixel, red, green, blue,
`ifdef WS2812_BRIGHTNESS_EN
        input  brightness,
`endif
        output data, busy, pixel_done
    );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// One-wire pulse-width encoder for a single bit: counts the bit period and drives
// data high for the first T0H/T1H cycles. Disabled means idle-low with the counter cleared.
module ws2812_bit_encoder
    import ws2812_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_val,
    input  logic enable,
    output logic data,
    output logic bit_end
);

    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] high_cycles;

    assign high_cycles = bit_val ? CNT_W'(T1H_CYCLES) : CNT_W'(T0H_CYCLES);
    assign bit_end     = (cycle_cnt == CNT_W'(CYCLES_PER_BIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            data      <= 1'b0;
        end else if (!enable) begin
            cycle_cnt <= '0;
            data      <= 1'b0;
        end else begin
            data      <= (cycle_cnt < high_cycles);
            cycle_cnt <= bit_end ? '0 : cycle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Serialises one GRB pixel onto the WS2812B data line: shift register, bit counter and FSM.
// Build option WS2812_BRIGHTNESS_EN scales each channel at load time.
module ws2812_pixel_serializer
    import ws2812_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ws2812_pixel_serializer_if.slave bus
);

    ser_state_t             state_q, state_d;
    logic [23:0]            shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   enc_en;
    logic                   bit_end;
    logic                   enc_data;
    logic                   pixel_done_q;
    rgb_t                   load_px;

`ifdef WS2812_BRIGHTNESS_EN
    assign load_px = '{g: scale_channel(bus.green, bus.brightness),
                       r: scale_channel(bus.red,   bus.brightness),
                       b: scale_channel(bus.blue,  bus.brightness)};
`else
    assign load_px = '{g: bus.green, r: bus.red, b: bus.blue};
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        enc_en  = 1'b0;
        if (bus.load_sreg) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.transmit_pixel) begin
                        state_d = SHIFT;
                        enc_en  = 1'b1;
                    end
                end
                SHIFT: begin
                    if (!bus.transmit_pixel) begin
                        state_d = IDLE;
                    end else begin
                        enc_en = 1'b1;
                        if (bit_end && bit_cnt == BIT_CNT_W'(BITS_PER_PIXEL - 1))
                            state_d = DONE;
                    end
                end
                DONE: begin
                    if (!bus.transmit_pixel)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Abort and load both clear the bit count; only load replaces the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            pixel_done_q <= 1'b0;
        end else begin
            pixel_done_q <= (state_q == SHIFT) && (state_d == DONE);
            if (bus.load_sreg) begin
                shift_reg <= load_px;
                bit_cnt   <= '0;
            end else if (state_d == IDLE) begin
                bit_cnt   <= '0;
            end else if (enc_en && bit_end) begin
                shift_reg <= {shift_reg[22:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

    ws2812_bit_encoder u_bit_encoder (
        .clk     (clk),
        .rst     (rst),
        .bit_val (shift_reg[23]),
        .enable  (enc_en),
        .data    (enc_data),
        .bit_end (bit_end)
    );

    assign bus.data       = enc_data;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.pixel_done = pixel_done_q;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Self-checking bench for ws2812_pixel_serializer: vector table, hand sequences and random
// pixels compared against a cycle-indexed waveform model.
module tb_ws2812_pixel_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ws2812_pixel_serializer_if bus ();

    ws2812_pixel_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        int         hold;
        int         exp_high;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line level in cycle n (1-based) after transmit starts: bit (n-1)/15 of the
    // pixel, MSB first, high for 10 cycles if set else 5; low once all 24 bits have gone.
    function automatic logic model_data(input logic [23:0] px, input int n);
        int idx, phase;
        if (n < 1 || n > 360) return 1'b0;
        idx   = (n - 1) / 15;
        phase = (n - 1) % 15;
        return phase < (px[23 - idx] ? 10 : 5);
    endfunction

    function automatic logic [7:0] scale_ref(input logic [7:0] ch, input logic [7:0] br);
`ifdef WS2812_BRIGHTNESS_EN
        return 8'((int'(ch) * (int'(br) + 1)) / 256);
`else
        return ch + 8'(br & 8'h00);
`endif
    endfunction

    task automatic set_brightness(input logic [7:0] br);
`ifdef WS2812_BRIGHTNESS_EN
        bus.brightness = br;
`else
        if (br != 8'hFF) $display("note: brightness %0h ignored in this build", br);
`endif
    endtask

    task automatic load_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        bus.green     = g;
        bus.red       = r;
        bus.blue      = b;
        bus.load_sreg = 1'b1;
        @(negedge clk);
        bus.load_sreg = 1'b0;
    endtask

    // Raise transmit_pixel for `hold` cycles and compare each cycle to the model.
    task automatic run_tx(input string name, input logic [23:0] px, input int hold, output int highs);
        int mism, first_bad, dones, done_at;
        mism = 0; first_bad = 0; dones = 0; done_at = 0; highs = 0;
        bus.transmit_pixel = 1'b1;
        for (int n = 1; n <= hold; n++) begin
            @(negedge clk);
            if (bus.data !== model_data(px, n)) begin
                mism++;
                if (first_bad == 0) first_bad = n;
            end
            if (bus.data === 1'b1) highs++;
            if (bus.pixel_done === 1'b1) begin
                dones++;
                done_at = n;
            end
            if (n == 150) check({name, "_busy_mid"}, 32'(bus.busy), 32'd1);
        end
        bus.transmit_pixel = 1'b0;
        @(negedge clk);
        if (bus.pixel_done === 1'b1) dones++;
        check({name, "_stream_mismatches"}, 32'(mism), 32'd0);
        if (mism != 0) $display("  %s first bad cycle %0d", name, first_bad);
        check({name, "_data_after_drop"}, 32'(bus.data), 32'd0);
        check({name, "_busy_after_drop"}, 32'(bus.busy), 32'd0);
        check({name, "_done_count"}, 32'(dones), (hold >= 360) ? 32'd1 : 32'd0);
        if (hold >= 360) check({name, "_done_cycle"}, 32'(done_at), 32'd360);
    endtask

    initial begin
        int highs;
        logic [7:0] g, r, b, br;

        bus.load_sreg      = 1'b0;
        bus.transmit_pixel = 1'b0;
        bus.red            = '0;
        bus.green          = '0;
        bus.blue           = '0;
        set_brightness(8'hFF);

        vecs[0] = '{g: 8'h80, r: 8'h00, b: 8'h01, hold: 360, exp_high: 130};
        vecs[1] = '{g: 8'hFF, r: 8'hFF, b: 8'hFF, hold: 360, exp_high: 240};
        vecs[2] = '{g: 8'h00, r: 8'h00, b: 8'h00, hold: 360, exp_high: 120};
        vecs[3] = '{g: 8'hFF, r: 8'hFF, b: 8'hFF, hold: 400, exp_high: 240};
        vecs[4] = '{g: 8'hA5, r: 8'h3C, b: 8'h0F, hold: 360, exp_high: 180};

        repeat (3) @(negedge clk);
        check("reset_data", 32'(bus.data), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_pixel_done", 32'(bus.pixel_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            load_pixel(vecs[i].g, vecs[i].r, vecs[i].b);
            run_tx($sformatf("vec%0d", i), {vecs[i].g, vecs[i].r, vecs[i].b}, vecs[i].hold, highs);
            check($sformatf("vec%0d_high_total", i), 32'(highs), 32'(vecs[i].exp_high));
        end

        // Abort after 100 cycles, then reload zeros and send a full pixel.
        load_pixel(8'h12, 8'h34, 8'h56);
        run_tx("abort", 24'h123456, 100, highs);
        load_pixel(8'h00, 8'h00, 8'h00);
        run_tx("after_abort", 24'h000000, 360, highs);
        check("after_abort_high_total", 32'(highs), 32'd120);

        // Asynchronous reset in the middle of a '1' pulse.
        load_pixel(8'hFF, 8'hFF, 8'hFF);
        bus.transmit_pixel = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_pre_data", 32'(bus.data), 32'd1);
        check("rst_pre_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_data", 32'(bus.data), 32'd0);
        check("rst_async_busy", 32'(bus.busy), 32'd0);
        bus.transmit_pixel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_tx("post_rst", 24'h000000, 360, highs);
        check("post_rst_high_total", 32'(highs), 32'd120);

        // Load during SHIFT with transmit held: restart, first pulse one cycle after the load.
        load_pixel(8'h00, 8'h00, 8'h00);
        bus.transmit_pixel = 1'b1;
        repeat (40) @(negedge clk);
        bus.green     = 8'hFF;
        bus.red       = 8'hFF;
        bus.blue      = 8'hFF;
        bus.load_sreg = 1'b1;
        @(negedge clk);
        check("restart_load_data", 32'(bus.data), 32'd0);
        check("restart_load_busy", 32'(bus.busy), 32'd0);
        bus.load_sreg = 1'b0;
        run_tx("restart", 24'hFFFFFF, 360, highs);
        check("restart_high_total", 32'(highs), 32'd240);

`ifdef WS2812_BRIGHTNESS_EN
        set_brightness(8'h7F);
        load_pixel(8'hFF, 8'h00, 8'h00);
        run_tx("bright_7f", {8'h7F, 16'h0000}, 360, highs);
        check("bright_7f_high_total", 32'(highs), 32'd155);
        set_brightness(8'h00);
        load_pixel(8'hFF, 8'hFF, 8'hFF);
        run_tx("bright_00", 24'h000000, 360, highs);
        check("bright_00_high_total", 32'(highs), 32'd120);
`endif

        for (int i = 0; i < 6; i++) begin
            g  = 8'($urandom);
            r  = 8'($urandom);
            b  = 8'($urandom);
`ifdef WS2812_BRIGHTNESS_EN
            br = 8'($urandom);
`else
            br = 8'hFF;
`endif
            set_brightness(br);
            load_pixel(g, r, b);
            run_tx($sformatf("rand%0d", i),
                   {scale_ref(g, br), scale_ref(r, br), scale_ref(b, br)}, 360, highs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
